mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
//  Round-robin arbiter sharing one pipelined 24x24 multiplier (LUT or DSP mult_gen) between N_REQ requesters.
//  Per cycle: grants at most one valid request, registers {B,A} into the multiplier.
//  Carries a requester tag down a delay line matched to the multiplier latency, so each product returns tagged.
//  Sits between the load-generator traffic sources and the multiplier wrapper; also counts issued operations.
// PARAMETERS
//  N_REQ    4  number of requesters (2..2**ID_W)
//  ID_W     2  width of requester tag
//  MULT_LAT 4  multiplier latency in CLK cycles from A/B to P (>=1)
// PORTS
//  CLK        in   1         single clock, all logic rising-edge
//  RST_N      in   1         synchronous reset, active low
//  ENABLE     in   1         1 = grants allowed; 0 = stop granting, drain in-flight ops
//  REQ_VALID  in   N_REQ     request i valid
//  REQ_DATA   in   N_REQ*48  request i operands, slice [48i+47:48i]; A=[23:0], B=[47:24]
//  REQ_READY  out  N_REQ     one-hot grant; handshake completes when VALID&READY
//  MULT_A     out  24        registered operand A to multiplier
//  MULT_B     out  24        registered operand B to multiplier
//  MULT_P     in   48        multiplier product, valid MULT_LAT cycles after MULT_A/B
//  RESP_VALID out  1         product on RESP_DATA valid, single-cycle pulse, no backpressure
//  RESP_ID    out  ID_W      requester index of current RESP_DATA
//  RESP_DATA  out  48        product = MULT_P passed through combinationally
//  BUSY       out  1         state != IDLE
//  ISSUE_CNT  out  32        total accepted requests since reset, wraps 2^32-1 -> 0
// BEHAVIOUR
//  Reset (RST_N=0 at edge):
//   - REQ_READY=0, MULT_A=MULT_B=0, RESP_VALID=0, RESP_ID=0, BUSY=0, ISSUE_CNT=0.
//   - RR pointer=0, all tag valids cleared, state=IDLE.
//   - Mid-operation reset discards in-flight ops; no RESP_VALID until new issues complete.
//  State machine:
//   - IDLE->RUN when ENABLE=1.
//   - RUN->DRAIN when ENABLE=0 and any tag valid in flight; RUN->IDLE when ENABLE=0 and pipe empty.
//   - DRAIN->IDLE when pipe empty; DRAIN->RUN if ENABLE returns to 1.
//  Grant (combinational, state=RUN and ENABLE=1 only):
//   - Lowest index i >= ptr with REQ_VALID[i] (circular), else none.
//   - REQ_READY[i]=1 only for the granted i; REQ_READY never asserted without REQ_VALID.
//   - On accept: ptr <= (i+1) mod N_REQ; ptr unchanged if no grant.
//  Issue stage, cycle after accept (edge t):
//   - MULT_A/B <= granted slice; tag stage0 <= {1,i}; ISSUE_CNT++.
//   - No grant: MULT_A/B hold value; tag stage0 valid=0.
//  Tag delay line: MULT_LAT stages. At edge t+MULT_LAT, RESP_VALID=1 and RESP_ID=i during the cycle after.
//  Latency: REQ accept at edge t -> RESP_VALID high in cycle following edge t+MULT_LAT (MULT_LAT+1 edges).
//  Throughput: one op/cycle sustained; no requester starves (<= N_REQ-1 cycles wait while valid).
//  ENABLE falling same cycle as a valid request: no grant that cycle.
//  Requester must hold REQ_DATA stable while VALID=1 and READY=0. Dropping VALID before grant is allowed (withdrawn).
//  Arithmetic: product width 48 = 24+24 unsigned; block does not alter MULT_P.
// TESTING
//  1 Reset: hold RST_N=0 3 cycles with all REQ_VALID=1 -> REQ_READY=0, RESP_VALID=0, ISSUE_CNT=0 throughout.
//  2 Single op: ENABLE=1, req0 A=5 B=3 -> READY[0] same cycle; RESP_VALID, RESP_ID=0, RESP_DATA=15, MULT_LAT+1 edges later.
//  3 Fairness: all 4 VALID continuously 8 cycles -> grant order 0,1,2,3,0,1,2,3; ISSUE_CNT=8; responses in same order.
//  4 Drain: issue 3 ops then ENABLE=0 -> no new READY, BUSY=1 until 3rd RESP_VALID, then IDLE (BUSY=0) next cycle.
//  5 Reset mid-flight: 2 ops in pipe, RST_N=0 one cycle -> no RESP_VALID for the 2 ops; ISSUE_CNT=0.
//  6 Wrap/skip: preload ISSUE_CNT near 2^32-1 (force), 2 issues -> reads 0 then 1; req1,req3 only valid -> grants alternate 1,3.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// mult_share_arbiter
//   Round-robin arbiter that lets N_REQ requesters share one pipelined 24x24
//   unsigned multiplier. At most one request is granted per cycle. The granted
//   operands are registered onto MULT_A/MULT_B. A requester tag travels down a
//   delay line that matches the multiplier latency, so every product comes back
//   labelled with the index of the requester that issued it. The block also
//   counts issued operations.
//
// Ports
//   CLK        in   single clock, rising edge
//   RST_N      in   synchronous reset, active low
//   ENABLE     in   1 = grants allowed, 0 = stop granting and drain in-flight ops
//   REQ_VALID  in   [N_REQ]     per-requester request valid
//   REQ_DATA   in   [N_REQ*48]  requester i operands at [48i+47:48i], A=[23:0], B=[47:24]
//   REQ_READY  out  [N_REQ]     one-hot grant, handshake on VALID & READY
//   MULT_A     out  [24]        registered operand A to multiplier
//   MULT_B     out  [24]        registered operand B to multiplier
//   MULT_P     in   [48]        product, valid MULT_LAT cycles after MULT_A/B
//   RESP_VALID out  1           single-cycle product valid pulse
//   RESP_ID    out  [ID_W]      requester index of the product on RESP_DATA
//   RESP_DATA  out  [48]        MULT_P passed through unchanged
//   BUSY       out  1           controller not idle
//   ISSUE_CNT  out  [32]        accepted requests since reset, wraps
// -----------------------------------------------------------------------------
module mult_share_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int MULT_LAT = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ENABLE,
  input  logic [N_REQ-1:0]      REQ_VALID,
  input  logic [N_REQ*48-1:0]   REQ_DATA,
  output logic [N_REQ-1:0]      REQ_READY,
  output logic [23:0]           MULT_A,
  output logic [23:0]           MULT_B,
  input  logic [47:0]           MULT_P,
  output logic                  RESP_VALID,
  output logic [ID_W-1:0]       RESP_ID,
  output logic [47:0]           RESP_DATA,
  output logic                  BUSY,
  output logic [31:0]           ISSUE_CNT
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state;
  logic [ID_W-1:0]  ptr;
  logic             grant_vld;
  logic [ID_W-1:0]  grant_id;
  logic [47:0]      sel_data;
  int               rr_idx;
  logic             in_flight;
  logic [31:0]      issue_cnt_q;

  // Tag delay line: entry 0 is written on the issue edge, entry MULT_LAT lines
  // up with the cycle in which MULT_P holds that operation's product.
  logic [MULT_LAT:0] tag_vld_p;
  logic [ID_W-1:0]   tag_id_p [MULT_LAT+1];

  // The response entry is excluded: the pipe counts as empty while the last
  // product is being presented, so DRAIN leaves on the following edge.
  assign in_flight = |tag_vld_p[MULT_LAT-1:0];

  // Grant: first valid requester at or after the pointer, scanning circularly.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    rr_idx    = 0;
    REQ_READY = '0;
    if (RST_N && state == ST_RUN && ENABLE) begin
      for (int k = 0; k < N_REQ; k++) begin
        rr_idx = int'(ptr) + k;
        if (rr_idx >= N_REQ) rr_idx = rr_idx - N_REQ;
        if (!grant_vld && REQ_VALID[ID_W'(rr_idx)]) begin
          grant_vld = 1'b1;
          grant_id  = ID_W'(rr_idx);
        end
      end
      if (grant_vld) REQ_READY[grant_id] = 1'b1;
    end
  end

  assign sel_data = REQ_DATA[grant_id*48 +: 48];

  // Control: state machine and round-robin pointer.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      if (grant_vld) begin
        ptr <= (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
      end
      case (state)
        ST_IDLE:  if (ENABLE) state <= ST_RUN;
        ST_RUN:   if (!ENABLE) state <= in_flight ? ST_DRAIN : ST_IDLE;
        ST_DRAIN: begin
          if (ENABLE)          state <= ST_RUN;
          else if (!in_flight) state <= ST_IDLE;
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Issue stage (p0): operands to the multiplier, tag entry 0, issue counter.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      MULT_A      <= '0;
      MULT_B      <= '0;
      issue_cnt_q <= '0;
    end else if (grant_vld) begin
      MULT_A      <= sel_data[23:0];
      MULT_B      <= sel_data[47:24];
      issue_cnt_q <= issue_cnt_q + 32'd1;
    end
  end

  // Tag pipeline p0 .. pMULT_LAT, matched to the multiplier latency.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tag_vld_p <= '0;
      for (int k = 0; k <= MULT_LAT; k++) tag_id_p[k] <= '0;
    end else begin
      tag_vld_p[0] <= grant_vld;
      tag_id_p[0]  <= grant_id;
      for (int k = 1; k <= MULT_LAT; k++) begin
        tag_vld_p[k] <= tag_vld_p[k-1];
        tag_id_p[k]  <= tag_id_p[k-1];
      end
    end
  end

  assign RESP_VALID = tag_vld_p[MULT_LAT];
  assign RESP_ID    = tag_id_p[MULT_LAT];
  assign RESP_DATA  = MULT_P;
  assign BUSY       = (state != ST_IDLE);
  assign ISSUE_CNT  = issue_cnt_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_share_arbiter
//   Scoreboard bench for mult_share_arbiter with a behavioural pipelined
//   multiplier. Expected {id, product, response cycle} entries are queued on
//   each observed grant and popped when RESP_VALID is seen.
// -----------------------------------------------------------------------------
module tb_mult_share_arbiter;

  localparam int L = 4;

  typedef struct {
    logic [1:0]  id;
    logic [47:0] data;
    int          cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic [3:0]   req_valid;
  logic [191:0] req_data;
  logic [3:0]   req_ready;
  logic [23:0]  mult_a;
  logic [23:0]  mult_b;
  logic [47:0]  mult_p;
  logic         resp_valid;
  logic [1:0]   resp_id;
  logic [47:0]  resp_data;
  logic         busy;
  logic [31:0]  issue_cnt;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   resp_cnt = 0;
  int   last_resp_cyc = -1;
  exp_t sb_q[$];

  logic [23:0] req_a [4];
  logic [23:0] req_b [4];
  logic [47:0] p_pipe [L];

  mult_share_arbiter #(.N_REQ(4), .ID_W(2), .MULT_LAT(L)) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .ENABLE     (enable),
    .REQ_VALID  (req_valid),
    .REQ_DATA   (req_data),
    .REQ_READY  (req_ready),
    .MULT_A     (mult_a),
    .MULT_B     (mult_b),
    .MULT_P     (mult_p),
    .RESP_VALID (resp_valid),
    .RESP_ID    (resp_id),
    .RESP_DATA  (resp_data),
    .BUSY       (busy),
    .ISSUE_CNT  (issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: product appears L edges after the operands.
  always @(posedge clk) begin
    p_pipe[0] <= 48'(mult_a) * 48'(mult_b);
    for (int k = 1; k < L; k++) p_pipe[k] <= p_pipe[k-1];
  end
  assign mult_p = p_pipe[L-1];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Response side of the scoreboard.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      exp_t e;
      resp_cnt++;
      last_resp_cyc = cyc;
      if (sb_q.size() == 0) begin
        check_eq("resp_unexpected", 64'(1), 64'(0));
      end else begin
        e = sb_q.pop_front();
        check_eq("resp_id",   64'(resp_id),   64'(e.id));
        check_eq("resp_data", 64'(resp_data), 64'(e.data));
        check_eq("resp_cyc",  64'(cyc),       64'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] vld, input logic [3:0] exp_rdy, input string tag);
    req_valid = vld;
    for (int i = 0; i < 4; i++) req_data[i*48 +: 48] = {req_b[i], req_a[i]};
    #1;
    check_eq(tag, 64'(req_ready), 64'(exp_rdy));
    for (int i = 0; i < 4; i++) begin
      if (req_ready[i]) begin
        sb_q.push_back('{id: 2'(i), data: 48'(req_a[i]) * 48'(req_b[i]), cyc: cyc + 1 + L});
        req_a[i] = 24'($urandom);
        req_b[i] = 24'($urandom);
      end
    end
    tick();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    enable    = 1'b0;
    req_valid = '0;
    sb_q.delete();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) drive(4'b0000, 4'b0000, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit drained;
    int base;
    rst_n     = 1'b0;
    enable    = 1'b1;
    req_valid = 4'b1111;
    req_data  = '0;
    for (int i = 0; i < 4; i++) begin
      req_a[i] = 24'($urandom);
      req_b[i] = 24'($urandom);
    end

    // Reset held with every request valid.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rst_ready", 64'(req_ready),  64'(0));
      check_eq("rst_resp",  64'(resp_valid), 64'(0));
      check_eq("rst_cnt",   64'(issue_cnt),  64'(0));
      check_eq("rst_busy",  64'(busy),       64'(0));
    end
    rst_n = 1'b1; enable = 1'b0; req_valid = '0;
    tick();

    // Single operation 5*3.
    enable = 1'b1;
    #1;
    check_eq("idle_busy", 64'(busy), 64'(0));
    tick();
    check_eq("run_busy", 64'(busy), 64'(1));
    req_a[0] = 24'd5; req_b[0] = 24'd3;
    check_eq("single_exp", 64'(48'(req_a[0]) * 48'(req_b[0])), 64'(15));
    drive(4'b0001, 4'b0001, "single_rdy");
    check_eq("single_mult_a", 64'(mult_a), 64'(5));
    check_eq("single_mult_b", 64'(mult_b), 64'(3));
    idle_cycles(L + 2, "single_idle");
    check_eq("single_drained", 64'(sb_q.size()), 64'(0));

    // Fairness with all four requesters valid.
    do_reset();
    enable = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) drive(4'b1111, 4'(1 << (k % 4)), "rr_grant");
    check_eq("rr_cnt", 64'(issue_cnt), 64'(8));
    idle_cycles(L + 2, "rr_idle");
    check_eq("rr_drained", 64'(sb_q.size()), 64'(0));

    // Drain: three ops, then ENABLE drops with a request still valid.
    do_reset();
    enable = 1'b1;
    tick();
    base = resp_cnt;
    for (int k = 0; k < 3; k++) drive(4'b0001, 4'b0001, "drain_issue");
    enable = 1'b0;
    drive(4'b0001, 4'b0000, "drain_noready");
    drained = 1'b0;
    for (int n = 0; n < 20 && !drained; n++) begin
      logic exp_busy;
      exp_busy = ((resp_cnt - base) < 3) || (cyc == last_resp_cyc);
      check_eq("drain_busy",  64'(busy),      64'(exp_busy));
      check_eq("drain_ready", 64'(req_ready), 64'(0));
      if (!exp_busy) drained = 1'b1;
      else tick();
    end
    check_eq("drain_done", 64'(drained), 64'(1));
    check_eq("drain_resps", 64'(resp_cnt - base), 64'(3));

    // Reset with two operations in flight.
    do_reset();
    enable = 1'b1;
    tick();
    base = resp_cnt;
    drive(4'b0001, 4'b0001, "midrst_issue");
    drive(4'b0001, 4'b0001, "midrst_issue");
    rst_n = 1'b0; req_valid = '0; enable = 1'b0;
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    check_eq("midrst_cnt", 64'(issue_cnt), 64'(0));
    for (int n = 0; n < L + 3; n++) begin
      tick();
      check_eq("midrst_resp", 64'(resp_valid), 64'(0));
    end
    check_eq("midrst_resps", 64'(resp_cnt - base), 64'(0));

    // Counter wrap and round-robin skip over idle requesters.
    do_reset();
    enable = 1'b1;
    tick();
    force dut.issue_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.issue_cnt_q;
    drive(4'b1010, 4'b0010, "skip_grant");
    check_eq("wrap_cnt0", 64'(issue_cnt), 64'(0));
    drive(4'b1010, 4'b1000, "skip_grant");
    check_eq("wrap_cnt1", 64'(issue_cnt), 64'(1));
    drive(4'b1010, 4'b0010, "skip_grant");
    drive(4'b1010, 4'b1000, "skip_grant");
    idle_cycles(L + 2, "skip_idle");
    check_eq("skip_drained", 64'(sb_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
